drac_adc_pwm_sequencer: RTL and testbench
=========================================

Name: drac_adc_pwm_sequencer

Overview:
- Per-board timing master for dRAC motor channels, clocked on pwmclk.
- Generates the shared unfolded PWM counter and the cycle-start strobe.
- Once per PWM period, at a programmable phase, runs one AD4008 conversion and readout: CNV high, then a gated SCK burst, then an adc_data_ready strobe, then a feedback_calculation_start strobe.
- Its outputs drive every MotorChannelDRAC instance, so current sampling and PI updates stay phase-locked to the PWM.

Parameters:
- COUNTER_WIDTH, 10, PWM half-period width; counter_unfolded is COUNTER_WIDTH+1 bits.
- CNV_CYCLES, 20, pwmclk cycles that adc_cnv stays high (conversion time), must be at least 1.
- SCK_HALF, 2, pwmclk cycles per SCK half-period, must be at least 1.
- ADC_BITS, 16, SCK pulses per readout.

Ports:
- pwmclk  input  1  sequencer clock
- rstn  input  1  asynchronous active-low reset
- enable  input  1  permits ADC trigger starts; counter runs regardless
- trigger_offset  input  COUNTER_WIDTH+1  counter_unfolded value that starts a sample (pwmclk domain)
- clear_overrun  input  1  synchronous clear of overrun_count
- counter_unfolded  output  COUNTER_WIDTH+1  free-running PWM counter
- pwm_cycle_start  output  1  one-cycle strobe at counter wrap
- adc_cnv  output  1  AD4008 convert
- adc_sck  output  1  AD4008 serial clock
- adc_data_ready  output  1  one-cycle strobe: ADC word complete
- feedback_calculation_start  output  1  one-cycle strobe: start PI update
- busy  output  1  sequence in progress
- overrun_count  output  8  saturating count of dropped triggers

Behaviour:
- Reset (rstn low, asynchronous):
  - counter_unfolded=0, pwm_cycle_start=0, adc_cnv=0, adc_sck=0, adc_data_ready=0, feedback_calculation_start=0, busy=0, overrun_count=0.
  - State goes to IDLE. Reset mid-sequence aborts it immediately.
- Counter:
  - counter_unfolded increments by 1 every cycle, wrapping from 2^(COUNTER_WIDTH+1)-1 to 0. Period is 2048 cycles at the default width.
  - pwm_cycle_start is registered. It is high exactly in cycles where counter_unfolded==0 that follow a wrap; it is not asserted in the first cycle after reset release.
- Trigger match: counter_unfolded==trigger_offset at a clock edge, with enable=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State machine: IDLE -> CONVERT -> READ -> DONE -> CALC -> IDLE.
  - IDLE: on a trigger match, go to CONVERT; adc_cnv=1 and busy=1 from the next cycle.
  - CONVERT: adc_cnv high for exactly CNV_CYCLES cycles, then go to READ with adc_cnv=0.
  - READ: ADC_BITS SCK periods. Each period is SCK_HALF cycles low followed by SCK_HALF cycles high, starting low; READ lasts 2*SCK_HALF*ADC_BITS cycles. A bit counter counts rising edges; after the high phase of pulse ADC_BITS, go to DONE.
  - DONE: adc_data_ready=1 for one cycle, sck=0.
  - CALC: feedback_calculation_start=1 for one cycle, then go to IDLE. busy deasserts in the cycle after CALC.
  - busy is high from the first CONVERT cycle through the CALC cycle. Total is CNV_CYCLES + 2*SCK_HALF*ADC_BITS + 2 cycles (86 at defaults).
- Overrun:
  - A trigger match while state is not IDLE is dropped; no restart occurs.
  - overrun_count increments, saturating at 255.
  - clear_overrun forces the count to 0. If clear_overrun and a dropped trigger occur in the same cycle, the result is 1.
- enable deasserted mid-sequence: the sequence completes normally, including both strobes, so the ADC is never left mid-transfer. No new starts occur while enable=0, and disabled matches are not counted as overruns.
- trigger_offset:
  - Sampled only at comparison. Changes take effect at the next match.
  - trigger_offset=0 starts in the same cycle that pwm_cycle_start is asserted; this is legal.
- adc_sck is held low in every state except the READ high phases.

Test Plan:
- Reset/counter: release rstn -> counter_unfolded steps 0,1,2…; pwm_cycle_start first high when the counter returns to 0 after 2047, then every 2048 cycles; all other outputs stay 0 with enable=0.
- Nominal sequence: defaults, trigger_offset=1024, enable=1 ->
  - adc_cnv high while counter_unfolded=1025..1044.
  - 16 sck pulses during 1045..1108, low-first, 2 cycles per phase.
  - adc_data_ready high only at 1109; feedback_calculation_start high only at 1110.
  - busy high 1025..1110; overrun_count stays 0.
- Overrun: COUNTER_WIDTH=5 (period 64), trigger_offset=0, enable=1 ->
  - The trigger at the second wrap is dropped; starts occur at every other wrap.
  - overrun_count=2 after 4 periods from the first start.
  - Pulsing clear_overrun in the same cycle as a dropped match gives a count of 1.
- Enable drop: deassert enable at counter_unfolded=1050 in the nominal setup -> readout finishes, adc_data_ready at 1109 and feedback_calculation_start at 1110; no cnv in the following period; overrun_count=0.
- Reset mid-readout: assert rstn low at counter_unfolded=1060 -> adc_sck, busy and all other outputs are 0 immediately; after release, the counter restarts at 0 and the next sample begins at 1025.
- Offset edge: trigger_offset=2047 -> adc_cnv rises in the cycle where the counter is 0, coincident with pwm_cycle_start; the sequence wraps across the period boundary correctly.

Source files
------------

// File: rtl/drac_adc_pwm_sequencer_if.sv
// Bundles the sequencer control inputs and its timing/ADC outputs.
//   enable, trigger_offset, clear_overrun        : control into the sequencer
//   counter_unfolded, pwm_cycle_start            : shared PWM timebase
//   adc_cnv, adc_sck                             : AD4008 pins
//   adc_data_ready, feedback_calculation_start   : per-period strobes to motor channels
//   busy, overrun_count                          : status
// master = sequencer side, slave = controller/consumer side.
interface drac_adc_pwm_sequencer_if #(
    parameter int unsigned COUNTER_WIDTH = 10
);
    logic                     enable;
    logic [COUNTER_WIDTH:0]   trigger_offset;
    logic                     clear_overrun;
    logic [COUNTER_WIDTH:0]   counter_unfolded;
    logic                     pwm_cycle_start;
    logic                     adc_cnv;
    logic                     adc_sck;
    logic                     adc_data_ready;
    logic                     feedback_calculation_start;
    logic                     busy;
    logic [7:0]               overrun_count;

    modport master (
        input  enable, trigger_offset, clear_overrun,
        output counter_unfolded, pwm_cycle_start, adc_cnv, adc_sck,
               adc_data_ready, feedback_calculation_start, busy, overrun_count
    );

    modport slave (
        output enable, trigger_offset, clear_overrun,
        input  counter_unfolded, pwm_cycle_start, adc_cnv, adc_sck,
               adc_data_ready, feedback_calculation_start, busy, overrun_count
    );
endinterface

// File: rtl/drac_adc_pwm_sequencer.sv
// Per-board PWM timing master: free-running unfolded PWM counter, cycle-start
// strobe, and one AD4008 convert/readout sequence per period at a programmable
// counter phase, followed by data-ready and PI-start strobes.
// Ports:
//   pwmclk : sequencer clock
//   rstn   : asynchronous active-low reset
//   bus    : master view of drac_adc_pwm_sequencer_if (control in, timing/ADC out)
module drac_adc_pwm_sequencer #(
    parameter int unsigned COUNTER_WIDTH = 10,
    parameter int unsigned CNV_CYCLES    = 20,
    parameter int unsigned SCK_HALF      = 2,
    parameter int unsigned ADC_BITS      = 16
) (
    input  logic                             pwmclk,
    input  logic                             rstn,
    drac_adc_pwm_sequencer_if.master         bus
);

    localparam int unsigned CW   = COUNTER_WIDTH + 1;
    localparam int unsigned TMAX = (CNV_CYCLES > SCK_HALF) ? CNV_CYCLES : SCK_HALF;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned BW   = $clog2(ADC_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_READ,
        S_DONE,
        S_CALC
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           phase_q, phase_d;   // 0 = SCK low half, 1 = SCK high half
    logic [BW-1:0]  bits_q, bits_d;     // SCK rising edges issued so far
    logic [7:0]     ovr_q, ovr_d;
    logic           pcs_q, pcs_d;
    logic           cnv_q, cnv_d;
    logic           sck_q, sck_d;
    logic           rdy_q, rdy_d;
    logic           calc_q, calc_d;
    logic           busy_q, busy_d;

    logic           match_c;
    logic           drop_c;

    // Trigger match and dropped-trigger detection
    assign match_c = bus.enable && (cnt_q == bus.trigger_offset);
    assign drop_c  = match_c && (state_q != S_IDLE);

    // State and output registers
    always_ff @(posedge pwmclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            phase_q <= 1'b0;
            bits_q  <= '0;
            ovr_q   <= '0;
            pcs_q   <= 1'b0;
            cnv_q   <= 1'b0;
            sck_q   <= 1'b0;
            rdy_q   <= 1'b0;
            calc_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            phase_q <= phase_d;
            bits_q  <= bits_d;
            ovr_q   <= ovr_d;
            pcs_q   <= pcs_d;
            cnv_q   <= cnv_d;
            sck_q   <= sck_d;
            rdy_q   <= rdy_d;
            calc_q  <= calc_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        tmr_d   = tmr_q;
        phase_d = phase_q;
        bits_d  = bits_q;
        ovr_d   = ovr_q;
        // Counter at all-ones now means the next cycle is the post-wrap zero
        pcs_d   = (cnt_q == {CW{1'b1}});

        unique case (state_q)
            S_IDLE: begin
                if (match_c) begin
                    state_d = S_CONVERT;
                    tmr_d   = '0;
                end
            end
            S_CONVERT: begin
                if (tmr_q == TW'(CNV_CYCLES - 1)) begin
                    state_d = S_READ;
                    tmr_d   = '0;
                    phase_d = 1'b0;
                    bits_d  = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_READ: begin
                if (tmr_q == TW'(SCK_HALF - 1)) begin
                    tmr_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        // High half of the last pulse just ended
                        if (bits_q == BW'(ADC_BITS)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        phase_d = 1'b1;
                        bits_d  = bits_q + BW'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Saturating overrun counter; a same-cycle clear keeps the new drop
        if (bus.clear_overrun) begin
            ovr_d = drop_c ? 8'd1 : 8'd0;
        end else if (drop_c && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        cnv_d  = (state_d == S_CONVERT);
        sck_d  = (state_d == S_READ) && phase_d;
        rdy_d  = (state_d == S_DONE);
        calc_d = (state_d == S_CALC);
        busy_d = (state_d != S_IDLE);
    end

    assign bus.counter_unfolded           = cnt_q;
    assign bus.pwm_cycle_start            = pcs_q;
    assign bus.adc_cnv                    = cnv_q;
    assign bus.adc_sck                    = sck_q;
    assign bus.adc_data_ready             = rdy_q;
    assign bus.feedback_calculation_start = calc_q;
    assign bus.busy                       = busy_q;
    assign bus.overrun_count              = ovr_q;

endmodule

// File: tb/tb_drac_adc_pwm_sequencer.sv
// Bench for drac_adc_pwm_sequencer: a default-width instance and a 5-bit-width
// instance, both checked every cycle against a timeline model, plus table-driven
// and hand-written directed sequences.
module tb_drac_adc_pwm_sequencer;

    localparam int unsigned W0  = 10;
    localparam int unsigned W1  = 5;
    localparam int          CNV = 20;
    localparam int          SH  = 2;
    localparam int          AB  = 16;
    localparam int          SEQ = CNV + 2 * SH * AB + 2;

    logic pwmclk = 1'b0;
    logic rstn;

    always #5 pwmclk = ~pwmclk;

    drac_adc_pwm_sequencer_if #(.COUNTER_WIDTH(W0)) bus0 ();
    drac_adc_pwm_sequencer_if #(.COUNTER_WIDTH(W1)) bus1 ();

    drac_adc_pwm_sequencer #(.COUNTER_WIDTH(W0), .CNV_CYCLES(CNV), .SCK_HALF(SH), .ADC_BITS(AB))
        dut0 (.pwmclk(pwmclk), .rstn(rstn), .bus(bus0));
    drac_adc_pwm_sequencer #(.COUNTER_WIDTH(W1), .CNV_CYCLES(CNV), .SCK_HALF(SH), .ADC_BITS(AB))
        dut1 (.pwmclk(pwmclk), .rstn(rstn), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: cycle index since reset release, start cycle of the latest
    // sequence (first CONVERT cycle), and the overrun count.
    longint mt[2]   = '{0, 0};
    longint ms[2]   = '{-1000000, -1000000};
    int     movr[2] = '{0, 0};

    typedef struct {
        int cnt;
        bit cnv;
        bit sck;
        bit rdy;
        bit calc;
        bit busy;
    } vec_t;

    function automatic longint period(input int d);
        return (d == 0) ? (longint'(1) << (W0 + 1)) : (longint'(1) << (W1 + 1));
    endfunction

    function automatic bit m_busy(input int d, input longint tt);
        longint r = tt - ms[d];
        return (r >= 0) && (r < SEQ);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int d, input bit en, input longint off, input bit clr);
        longint c     = mt[d] % period(d);
        bit     match = en && (c == off);
        bit     drop  = match && m_busy(d, mt[d]);
        if (match && !drop) ms[d] = mt[d] + 1;
        if (clr) movr[d] = drop ? 1 : 0;
        else if (drop && movr[d] < 255) movr[d] = movr[d] + 1;
        mt[d] = mt[d] + 1;
    endtask

    task automatic model_check(input int d, input longint cnt, input longint pcs,
                               input longint cnv, input longint sck, input longint rdy,
                               input longint calc, input longint busy, input longint ovr);
        longint tt = mt[d];
        longint r  = tt - ms[d];
        longint c  = tt % period(d);
        string  p  = (d == 0) ? "d0" : "d1";
        chk({p, ".counter"}, cnt, c);
        chk({p, ".pwm_cycle_start"}, pcs, longint'(tt > 0 && c == 0));
        chk({p, ".adc_cnv"}, cnv, longint'(r >= 0 && r < CNV));
        chk({p, ".adc_sck"}, sck,
            longint'(r >= CNV && r < CNV + 2 * SH * AB && ((r - CNV) / SH) % 2 == 1));
        chk({p, ".adc_data_ready"}, rdy, longint'(r == SEQ - 2));
        chk({p, ".feedback_start"}, calc, longint'(r == SEQ - 1));
        chk({p, ".busy"}, busy, longint'(r >= 0 && r < SEQ));
        chk({p, ".overrun_count"}, ovr, longint'(movr[d]));
    endtask

    always @(negedge rstn) begin
        for (int d = 0; d < 2; d++) begin
            mt[d]   = 0;
            ms[d]   = -1000000;
            movr[d] = 0;
        end
    end

    always @(posedge pwmclk) begin
        if (rstn) begin
            model_edge(0, bus0.enable, longint'(bus0.trigger_offset), bus0.clear_overrun);
            model_edge(1, bus1.enable, longint'(bus1.trigger_offset), bus1.clear_overrun);
        end
    end

    always @(negedge pwmclk) begin
        model_check(0, bus0.counter_unfolded, bus0.pwm_cycle_start, bus0.adc_cnv, bus0.adc_sck,
                    bus0.adc_data_ready, bus0.feedback_calculation_start, bus0.busy,
                    bus0.overrun_count);
        model_check(1, bus1.counter_unfolded, bus1.pwm_cycle_start, bus1.adc_cnv, bus1.adc_sck,
                    bus1.adc_data_ready, bus1.feedback_calculation_start, bus1.busy,
                    bus1.overrun_count);
    end

    // Advance to the next negedge where the selected counter equals val
    task automatic wait_cnt(input int d, input int val, input int budget);
        longint cur;
        for (int i = 0; i < budget; i++) begin
            @(negedge pwmclk);
            cur = (d == 0) ? longint'(bus0.counter_unfolded) : longint'(bus1.counter_unfolded);
            if (cur == val) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_cnt d%0d value %0d: not reached within %0d cycles", d, val, budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   n;

        tbl.push_back('{1024, 0, 0, 0, 0, 0});
        tbl.push_back('{1025, 1, 0, 0, 0, 1});
        tbl.push_back('{1044, 1, 0, 0, 0, 1});
        tbl.push_back('{1045, 0, 0, 0, 0, 1});
        tbl.push_back('{1046, 0, 0, 0, 0, 1});
        tbl.push_back('{1047, 0, 1, 0, 0, 1});
        tbl.push_back('{1048, 0, 1, 0, 0, 1});
        tbl.push_back('{1049, 0, 0, 0, 0, 1});
        tbl.push_back('{1106, 0, 0, 0, 0, 1});
        tbl.push_back('{1107, 0, 1, 0, 0, 1});
        tbl.push_back('{1108, 0, 1, 0, 0, 1});
        tbl.push_back('{1109, 0, 0, 1, 0, 1});
        tbl.push_back('{1110, 0, 0, 0, 1, 1});
        tbl.push_back('{1111, 0, 0, 0, 0, 0});

        bus0.enable = 1'b0; bus0.trigger_offset = '0; bus0.clear_overrun = 1'b0;
        bus1.enable = 1'b0; bus1.trigger_offset = '0; bus1.clear_overrun = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(negedge pwmclk);
        #2 rstn = 1'b1;

        // Reset state and counter start
        #1;
        chk("reset counter", bus0.counter_unfolded, 0);
        chk("reset pcs", bus0.pwm_cycle_start, 0);
        chk("reset busy", bus0.busy, 0);
        chk("reset overrun", bus0.overrun_count, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge pwmclk);
            chk("counter step", bus0.counter_unfolded, i);
        end
        n = 3;
        for (int i = 0; i < 3000; i++) begin
            @(negedge pwmclk);
            n++;
            if (bus0.pwm_cycle_start) break;
        end
        chk("first pcs cycle", n, 2048);
        chk("first pcs counter", bus0.counter_unfolded, 0);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge pwmclk);
            n++;
            if (bus0.pwm_cycle_start) break;
        end
        chk("pcs period", n, 2048);

        // Nominal sequence against the checkpoint table
        bus0.trigger_offset = 11'd1024;
        bus0.enable = 1'b1;
        foreach (tbl[k]) begin
            wait_cnt(0, tbl[k].cnt, 4096);
            chk($sformatf("tbl%0d cnv", tbl[k].cnt), bus0.adc_cnv, tbl[k].cnv);
            chk($sformatf("tbl%0d sck", tbl[k].cnt), bus0.adc_sck, tbl[k].sck);
            chk($sformatf("tbl%0d rdy", tbl[k].cnt), bus0.adc_data_ready, tbl[k].rdy);
            chk($sformatf("tbl%0d calc", tbl[k].cnt), bus0.feedback_calculation_start, tbl[k].calc);
            chk($sformatf("tbl%0d busy", tbl[k].cnt), bus0.busy, tbl[k].busy);
        end
        chk("nominal overrun", bus0.overrun_count, 0);

        // Enable dropped mid-readout: sequence completes, no new start
        wait_cnt(0, 1050, 4096);
        bus0.enable = 1'b0;
        wait_cnt(0, 1109, 4096);
        chk("endrop rdy", bus0.adc_data_ready, 1);
        wait_cnt(0, 1110, 4096);
        chk("endrop calc", bus0.feedback_calculation_start, 1);
        wait_cnt(0, 1025, 4096);
        chk("endrop no cnv", bus0.adc_cnv, 0);
        chk("endrop overrun", bus0.overrun_count, 0);

        // Reset mid-readout
        bus0.enable = 1'b1;
        wait_cnt(0, 2000, 4096);
        wait_cnt(0, 1060, 4096);
        chk("pre-reset busy", bus0.busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst counter", bus0.counter_unfolded, 0);
        chk("midrst sck", bus0.adc_sck, 0);
        chk("midrst busy", bus0.busy, 0);
        chk("midrst cnv", bus0.adc_cnv, 0);
        chk("midrst pcs", bus0.pwm_cycle_start, 0);
        @(negedge pwmclk);
        #2 rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge pwmclk);
            n++;
            if (bus0.adc_cnv) break;
        end
        chk("post-reset start cycle", n, 1025);
        chk("post-reset start counter", bus0.counter_unfolded, 1025);

        // Offset at the last counter value: start coincides with the wrap
        bus0.trigger_offset = 11'd2047;
        wait_cnt(0, 2047, 4096);
        @(negedge pwmclk);
        chk("edge counter", bus0.counter_unfolded, 0);
        chk("edge pcs", bus0.pwm_cycle_start, 1);
        chk("edge cnv", bus0.adc_cnv, 1);
        wait_cnt(0, 85, 4096);
        chk("edge calc", bus0.feedback_calculation_start, 1);
        chk("edge busy end", bus0.busy, 1);
        @(negedge pwmclk);
        chk("edge idle", bus0.busy, 0);

        fork
            begin
                // Random stimulus on the default-width instance
                for (int i = 0; i < 33500; i++) begin
                    @(negedge pwmclk);
                    if ($urandom_range(0, 499) == 0) bus0.trigger_offset = 11'($urandom_range(0, 2047));
                    if ($urandom_range(0, 299) == 0) bus0.enable = ~bus0.enable;
                    bus0.clear_overrun = ($urandom_range(0, 199) == 0);
                end
                bus0.clear_overrun = 1'b0;
            end
            begin
                // Overrun on the 64-cycle-period instance
                bus1.trigger_offset = 6'd0;
                wait_cnt(1, 30, 200);
                bus1.enable = 1'b1;
                for (int i = 0; i < 200; i++) begin
                    @(negedge pwmclk);
                    if (bus1.busy) break;
                end
                chk("ovr first start counter", bus1.counter_unfolded, 1);
                repeat (256) @(negedge pwmclk);
                chk("ovr after 4 periods", bus1.overrun_count, 2);
                chk("ovr restart busy", bus1.busy, 1);
                wait_cnt(1, 0, 200);
                chk("ovr busy at drop", bus1.busy, 1);
                bus1.clear_overrun = 1'b1;
                @(negedge pwmclk);
                bus1.clear_overrun = 1'b0;
                chk("ovr clear with drop", bus1.overrun_count, 1);
                repeat (33000) @(negedge pwmclk);
                chk("ovr saturated", bus1.overrun_count, 255);
            end
        join

        // Random stimulus on the small instance
        bus0.enable = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge pwmclk);
            if ($urandom_range(0, 39) == 0) bus1.trigger_offset = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 49) == 0) bus1.enable = ~bus1.enable;
            bus1.clear_overrun = ($urandom_range(0, 99) == 0);
        end
        bus1.clear_overrun = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
